// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed flop memory, used as a loopback target for AXI4 masters.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst per direction.
module axi4_slave_mem #(
    parameter int unsigned P_MEM_DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [3:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [3:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [15:0] o_wr_burst_cnt,
    output logic [15:0] o_rd_burst_cnt
);

    localparam int unsigned IDX_W  = $clog2(P_MEM_DEPTH);
    localparam int unsigned BEAT_W = 9;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

    logic [31:0] mem [P_MEM_DEPTH];

    wr_state_t         wr_state, wr_state_nxt;
    logic [3:0]        wr_id;
    logic [IDX_W-1:0]  wr_idx;
    logic [7:0]        wr_len;
    logic              wr_fixed, wr_err;
    logic [BEAT_W-1:0] wr_beats;

    rd_state_t         rd_state, rd_state_nxt;
    logic [IDX_W-1:0]  rd_idx, rd_idx_nxt, ar_idx;
    logic [7:0]        rd_len, rd_beat;
    logic              rd_fixed, rd_err, ar_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Sideband fields carry no meaning for this responder; size is always treated as 4 bytes.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid  & s_axi_wready;
    assign b_hs   = s_axi_bvalid  & s_axi_bready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign r_hs   = s_axi_rvalid  & s_axi_rready;
    assign ar_idx = s_axi_araddr[IDX_W+1:2];
    assign ar_err = (s_axi_araddr[31:IDX_W+2] != '0);

    // Write channel next state
    always_comb begin
        wr_state_nxt = wr_state;
        unique case (wr_state)
            WR_IDLE: if (aw_hs)                wr_state_nxt = WR_DATA;
            WR_DATA: if (w_hs && s_axi_wlast)  wr_state_nxt = WR_RESP;
            WR_RESP: if (b_hs)                 wr_state_nxt = WR_IDLE;
            default:                           wr_state_nxt = WR_IDLE;
        endcase
    end

    // Write channel registers; handshake outputs follow the next state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_state       <= WR_IDLE;
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            s_axi_bvalid   <= 1'b0;
            s_axi_bid      <= '0;
            s_axi_bresp    <= RESP_OKAY;
            o_wr_burst_cnt <= '0;
            wr_id          <= '0;
            wr_idx         <= '0;
            wr_len         <= '0;
            wr_fixed       <= 1'b0;
            wr_err         <= 1'b0;
            wr_beats       <= '0;
        end else begin
            wr_state      <= wr_state_nxt;
            s_axi_awready <= (wr_state_nxt == WR_IDLE);
            s_axi_wready  <= (wr_state_nxt == WR_DATA);
            s_axi_bvalid  <= (wr_state_nxt == WR_RESP);
            if (aw_hs) begin
                wr_id    <= s_axi_awid;
                wr_idx   <= s_axi_awaddr[IDX_W+1:2];
                wr_len   <= s_axi_awlen;
                wr_fixed <= (s_axi_awburst == 2'b00);
                wr_err   <= (s_axi_awaddr[31:IDX_W+2] != '0);
                wr_beats <= '0;
            end
            if (w_hs) begin
                wr_beats <= wr_beats + BEAT_W'(1);
                if (!wr_fixed) wr_idx <= wr_idx + IDX_W'(1);
                // Beats seen before the last one must equal awlen for a clean burst
                if (s_axi_wlast) begin
                    s_axi_bid   <= wr_id;
                    s_axi_bresp <= (wr_err || (wr_beats != BEAT_W'(wr_len))) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            if (b_hs) o_wr_burst_cnt <= o_wr_burst_cnt + 16'(1);
        end
    end

    // Memory array, byte-lane writes, no reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_hs && !wr_err) begin
            for (int n = 0; n < 4; n++) begin
                if (s_axi_wstrb[n]) mem[wr_idx][8*n +: 8] <= s_axi_wdata[8*n +: 8];
            end
        end
    end

    // Read channel next state and next beat index
    always_comb begin
        rd_state_nxt = rd_state;
        rd_idx_nxt   = rd_fixed ? rd_idx : rd_idx + IDX_W'(1);
        unique case (rd_state)
            RD_IDLE: if (ar_hs)               rd_state_nxt = RD_DATA;
            RD_DATA: if (r_hs && s_axi_rlast) rd_state_nxt = RD_IDLE;
            default:                          rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read channel registers; rdata is loaded at AR and at each non-last R handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_state       <= RD_IDLE;
            s_axi_arready  <= 1'b0;
            s_axi_rvalid   <= 1'b0;
            s_axi_rlast    <= 1'b0;
            s_axi_rid      <= '0;
            s_axi_rdata    <= '0;
            s_axi_rresp    <= RESP_OKAY;
            o_rd_burst_cnt <= '0;
            rd_idx         <= '0;
            rd_len         <= '0;
            rd_fixed       <= 1'b0;
            rd_err         <= 1'b0;
            rd_beat        <= '0;
        end else begin
            rd_state      <= rd_state_nxt;
            s_axi_arready <= (rd_state_nxt == RD_IDLE);
            s_axi_rvalid  <= (rd_state_nxt == RD_DATA);
            if (ar_hs) begin
                s_axi_rid   <= s_axi_arid;
                rd_idx      <= ar_idx;
                rd_len      <= s_axi_arlen;
                rd_fixed    <= (s_axi_arburst == 2'b00);
                rd_err      <= ar_err;
                rd_beat     <= '0;
                s_axi_rdata <= ar_err ? 32'h0 : mem[ar_idx];
                s_axi_rresp <= ar_err ? RESP_SLVERR : RESP_OKAY;
                s_axi_rlast <= (s_axi_arlen == 8'd0);
            end else if (r_hs && !s_axi_rlast) begin
                rd_idx      <= rd_idx_nxt;
                rd_beat     <= rd_beat + 8'(1);
                s_axi_rdata <= rd_err ? 32'h0 : mem[rd_idx_nxt];
                s_axi_rlast <= ((rd_beat + 8'(1)) == rd_len);
            end else if (r_hs) begin
                s_axi_rlast    <= 1'b0;
                o_rd_burst_cnt <= o_rd_burst_cnt + 16'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: burst-level memory model, per-cycle compare of R/B and counters.
module tb_axi4_slave_mem;

    localparam int DEPTH = 256;
    localparam int LIMIT = 400;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'b010;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [3:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'b010;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [15:0] o_wr_burst_cnt;
    logic [15:0] o_rd_burst_cnt;

    axi4_slave_mem #(.P_MEM_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .o_wr_burst_cnt(o_wr_burst_cnt), .o_rd_burst_cnt(o_rd_burst_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] got_r[$];
    logic [31:0] model [DEPTH];
    logic [1:0]  last_bresp;
    int          n_pass = 0;
    int          n_chk = 0;
    int          wr_done = 0;
    int          rd_done = 0;
    bit          rand_r = 1'b0;

    logic [3:0] w_id;
    int         w_idx, w_len, w_beats;
    bit         w_err, w_fixed;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic bit m_err(input logic [31:0] a);
        return a >= 32'(4 * DEPTH);
    endfunction

    // Per-cycle compare of everything observable against the model queues
    initial forever begin
        @(negedge i_clk);
        if (!i_rst_n) begin
            wr_done = 0;
            rd_done = 0;
            continue;
        end
        check("wr_cnt", 32'(o_wr_burst_cnt), 32'(wr_done & 16'hFFFF));
        check("rd_cnt", 32'(o_rd_burst_cnt), 32'(rd_done & 16'hFFFF));
        if (s_axi_rvalid) begin
            if (exp_r.size() == 0) check("r_spurious", 32'(s_axi_rvalid), 32'd0);
            else begin
                rbeat_t e;
                e = exp_r[0];
                check("rdata", s_axi_rdata, e.data);
                check("rresp", 32'(s_axi_rresp), 32'(e.resp));
                check("rlast", 32'(s_axi_rlast), 32'(e.last));
                check("rid", 32'(s_axi_rid), 32'(e.id));
                if (s_axi_rready) begin
                    got_r.push_back(s_axi_rdata);
                    void'(exp_r.pop_front());
                    if (e.last) rd_done++;
                end
            end
        end
        if (s_axi_bvalid) begin
            if (exp_b.size() == 0) check("b_spurious", 32'(s_axi_bvalid), 32'd0);
            else begin
                check("bid", 32'(s_axi_bid), 32'(exp_b[0].id));
                check("bresp", 32'(s_axi_bresp), 32'(exp_b[0].resp));
                if (s_axi_bready) begin
                    last_bresp = s_axi_bresp;
                    void'(exp_b.pop_front());
                    wr_done++;
                end
            end
        end
    end

    initial forever begin
        @(posedge i_clk);
        #1;
        s_axi_rready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All driving tasks start and end at posedge+1
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
        int t = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        @(negedge i_clk);
        while (!s_axi_awready && t < LIMIT) begin @(negedge i_clk); t++; end
        if (t >= LIMIT) check("aw_timeout", 32'(t), 32'd0);
        @(posedge i_clk); #1;
        s_axi_awvalid = 1'b0;
        w_id = id; w_idx = m_idx(addr); w_err = m_err(addr); w_fixed = (burst == 2'b00);
        w_len = int'(len); w_beats = 0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input bit last);
        int t = 0;
        s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        @(negedge i_clk);
        while (!s_axi_wready && t < LIMIT) begin @(negedge i_clk); t++; end
        if (t >= LIMIT) check("w_timeout", 32'(t), 32'd0);
        @(posedge i_clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        if (!w_err) begin
            for (int n = 0; n < 4; n++) if (strb[n]) model[w_idx][8*n +: 8] = d[8*n +: 8];
        end
        w_beats++;
        if (!w_fixed) w_idx = (w_idx + 1) % DEPTH;
        if (last) exp_b.push_back('{id: w_id, resp: (w_err || w_beats != w_len + 1) ? 2'b10 : 2'b00});
    endtask

    task automatic wait_b();
        int t = 0;
        do begin @(posedge i_clk); t++; end while (exp_b.size() != 0 && t < LIMIT);
        if (exp_b.size() != 0) begin check("b_timeout", 32'(exp_b.size()), 32'd0); exp_b.delete(); end
        #1;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                            input int nbeats);
        do_aw(id, addr, len, burst);
        for (int i = 0; i < nbeats; i++) do_w(d0 + 32'(i), strb, i == nbeats - 1);
        wait_b();
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int  idx = m_idx(addr);
        bit  err = m_err(addr);
        int  t = 0;
        got_r.delete();
        for (int b = 0; b <= int'(len); b++) begin
            rbeat_t e;
            e.data = err ? 32'h0 : model[idx];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            e.id   = id;
            exp_r.push_back(e);
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        @(negedge i_clk);
        check("ar_ready", 32'(s_axi_arready), 32'd1);
        while (!s_axi_arready && t < LIMIT) begin @(negedge i_clk); t++; end
        @(posedge i_clk); #1;
        s_axi_arvalid = 1'b0;
        @(negedge i_clk);
        check("rd_latency", 32'(s_axi_rvalid), 32'd1);
        t = 0;
        do begin @(posedge i_clk); t++; end while (exp_r.size() != 0 && t < LIMIT);
        if (exp_r.size() != 0) begin check("r_timeout", 32'(exp_r.size()), 32'd0); exp_r.delete(); end
        #1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rlast", 32'(s_axi_rlast), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_ids", 32'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), 32'd0);
        check("rst_cnts", {o_wr_burst_cnt, o_rd_burst_cnt}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rel_awready", 32'(s_axi_awready), 32'd1);
        check("rel_arready", 32'(s_axi_arready), 32'd1);
        @(posedge i_clk); #1;

        // Write then read 16-beat INCR
        wr_burst(4'd1, 32'h0, 8'd15, 2'b01, 32'd0, 4'hF, 16);
        check("t1_bresp", 32'(last_bresp), 32'd0);
        check("t1_wcnt", 32'(o_wr_burst_cnt), 32'd1);
        rd_burst(4'd2, 32'h0, 8'd15, 2'b01);
        for (int i = 0; i < 16; i++) check("t1_rdata", got_r[i], 32'(i));
        check("t1_rcnt", 32'(o_rd_burst_cnt), 32'd1);

        // Random rready backpressure
        rand_r = 1'b1;
        rd_burst(4'd3, 32'h0, 8'd15, 2'b01);
        rand_r = 1'b0;
        for (int i = 0; i < 16; i++) check("bp_rdata", got_r[i], 32'(i));

        // bready held low for 10 cycles
        s_axi_bready = 1'b0;
        do_aw(4'd4, 32'h40, 8'd0, 2'b01);
        do_w(32'hCAFEBABE, 4'hF, 1'b1);
        repeat (10) begin
            @(negedge i_clk);
            check("bhold_bvalid", 32'(s_axi_bvalid), 32'd1);
            check("bhold_awready", 32'(s_axi_awready), 32'd0);
        end
        @(posedge i_clk); #1;
        s_axi_bready = 1'b1;
        wait_b();

        // Byte strobes
        wr_burst(4'd5, 32'h50, 8'd0, 2'b01, 32'h11223344, 4'hF, 1);
        wr_burst(4'd5, 32'h50, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 1);
        rd_burst(4'd6, 32'h50, 8'd0, 2'b01);
        check("strb_rdata", got_r[0], 32'h11BB33DD);

        // FIXED write, then INCR read wrapping past the top
        wr_burst(4'd7, 32'h10, 8'd3, 2'b00, 32'hF0, 4'hF, 4);
        rd_burst(4'd7, 32'h10, 8'd0, 2'b01);
        check("fixed_word4", got_r[0], 32'hF3);
        wr_burst(4'd8, 32'h3F8, 8'd1, 2'b01, 32'hE0, 4'hF, 2);
        rd_burst(4'd9, 32'h3F8, 8'd3, 2'b01);
        check("wrap_b0", got_r[0], 32'hE0);
        check("wrap_b1", got_r[1], 32'hE1);
        check("wrap_b2", got_r[2], 32'h0);
        check("wrap_b3", got_r[3], 32'h1);

        // Address error and short burst
        wr_burst(4'd10, 32'h400, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 1);
        check("err_wr_bresp", 32'(last_bresp), 32'd2);
        rd_burst(4'd11, 32'h0, 8'd0, 2'b01);
        check("err_wr_nomod", got_r[0], 32'h0);
        rd_burst(4'd12, 32'h400, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) check("err_rd_zero", got_r[i], 32'h0);
        wr_burst(4'd13, 32'h200, 8'd3, 2'b01, 32'h50, 4'hF, 3);
        check("short_bresp", 32'(last_bresp), 32'd2);

        // Read served while a write burst is open
        do_aw(4'd14, 32'h300, 8'd3, 2'b01);
        do_w(32'h60, 4'hF, 1'b0);
        do_w(32'h61, 4'hF, 1'b0);
        rd_burst(4'd15, 32'h0, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) check("conc_rdata", got_r[i], 32'(i));
        do_w(32'h62, 4'hF, 1'b0);
        do_w(32'h63, 4'hF, 1'b1);
        wait_b();
        rd_burst(4'd1, 32'h300, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) check("conc_wdata", got_r[i], 32'h60 + 32'(i));

        // Reset in the middle of a 16-beat write
        do_aw(4'd2, 32'h100, 8'd15, 2'b01);
        for (int i = 0; i < 5; i++) do_w(32'h70 + 32'(i), 4'hF, 1'b0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        check("mid_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, s_axi_wready, s_axi_awready, s_axi_arready}), 32'd0);
        check("mid_rst_cnts", {o_wr_burst_cnt, o_rd_burst_cnt}, 32'd0);
        exp_b.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("post_rst_ready", 32'({s_axi_awready, s_axi_arready}), 32'd3);
        check("post_rst_valid", 32'({s_axi_bvalid, s_axi_rvalid, s_axi_wready}), 32'd0);
        @(posedge i_clk); #1;
        rd_burst(4'd3, 32'h100, 8'd4, 2'b01);
        for (int i = 0; i < 5; i++) check("partial_kept", got_r[i], 32'h70 + 32'(i));
        check("post_rst_wcnt", 32'(o_wr_burst_cnt), 32'd0);
        check("post_rst_rcnt", 32'(o_rd_burst_cnt), 32'd1);

        repeat (3) @(posedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
